unified_mem_arbiter: RTL and testbench

Single-port memory arbiter for the 5-stage pipeline when instruction and data memory share one physical port. It arbitrates between instruction fetch (IF) and data access (MEM stage), runs one transaction at a time against a variable-latency memory, and returns read data. It raises a pipeline-wide stall while any request is outstanding, and drops the result of a fetch that is flushed while in flight.

---
 rtl/cpu_mem_pkg.sv | 15 +
 rtl/unified_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory subsystem: arbiter state and requester identity.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the MEM stage.
// One transaction at a time, round-robin on ties, drops flushed fetches.
module unified_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output arb_state_t        dbg_state
);

  // Handshakes: requesters hold x_req until the one-cycle x_valid pulse (IF may
  // also abandon via if_flush); mem_req is a level held with stable address/data
  // until the memory returns mem_ack, whose mem_rdata is valid in that same cycle.

  arb_state_t state, state_nxt;
  req_id_t    last_grant;
  logic       drop;
  logic       if_elig, dm_elig;
  logic       grant_if, grant_dm;

  // A requester whose valid pulses this cycle is retiring and must not be regranted.
  assign if_elig = if_req & ~if_flush & ~if_valid;
  assign dm_elig = dm_req & ~dm_valid;

  assign mem_req   = (state != IDLE);
  assign stall     = (if_req & ~if_valid & ~if_flush) | (dm_req & ~dm_valid);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_elig && (!dm_elig || last_grant == REQ_DM)) begin
          grant_if = 1'b1;
        end else if (dm_elig) begin
          grant_dm = 1'b1;
        end
        if (grant_if) begin
          state_nxt = BUSY_IF;
        end else if (grant_dm) begin
          state_nxt = BUSY_DM;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_valid   <= 1'b0;
      dm_rdata   <= '0;
      last_grant <= REQ_IF;
      drop       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (grant_if) begin
            mem_addr   <= if_addr;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            last_grant <= REQ_IF;
          end else if (grant_dm) begin
            mem_addr   <= dm_addr;
            mem_we     <= dm_we;
            mem_wdata  <= dm_wdata;
            last_grant <= REQ_DM;
          end
        end
        BUSY_IF: begin
          // A flush in the ack cycle itself also discards the fetched word.
          if (mem_ack) begin
            if (!(drop || if_flush)) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
            drop <= 1'b0;
          end else if (if_flush) begin
            drop <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (mem_ack) begin
            dm_valid <= 1'b1;
            dm_rdata <= mem_we ? '0 : mem_rdata;
            mem_we   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter with a variable-latency memory
// responder and per-requester expected-data queues.
module tb_unified_mem_arbiter;
  import cpu_mem_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  arb_state_t        dbg_state;

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] if_exp_q[$];
  logic [DATA_W-1:0] dm_exp_q[$];
  logic              grant_q[$];
  logic [DATA_W-1:0] mem_arr[0:255];
  logic [DATA_W-1:0] ref_arr[0:255];
  int                lat;
  bit                spur;
  int                wait_cnt;
  logic              prev_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h2008_0005 : (32'hA500_0000 | 32'(i));
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (mem_req) begin
        if (wait_cnt >= lat) begin
          mem_ack = 1'b1;
          if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
          else        mem_rdata = mem_arr[mem_addr[9:2]];
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (spur) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  initial prev_req = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (if_valid) begin
        if (if_exp_q.size() == 0) check("if_unexpected_valid", 32'(1), 32'(0));
        else check("if_rdata", if_rdata, if_exp_q.pop_front());
      end
      if (dm_valid) begin
        if (dm_exp_q.size() == 0) check("dm_unexpected_valid", 32'(1), 32'(0));
        else check("dm_rdata", dm_rdata, dm_exp_q.pop_front());
      end
      if (mem_req && !prev_req) grant_q.push_back(dbg_state == BUSY_DM);
    end
    prev_req = mem_req;
  end

  // ---------------- driver tasks ----------------
  task automatic if_fetch(input logic [31:0] a, input int exp_busy, input bit chk);
    int n, busy, stl;
    bit seen;
    if_exp_q.push_back(ref_arr[a[9:2]]);
    if_req  = 1'b1;
    if_addr = a;
    n = 0; busy = 0; stl = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_req) busy++;
      if (stall) stl++;
      if (if_valid) seen = 1'b1;
    end
    check("if_done", 32'(seen), 32'(1));
    if (chk) begin
      check("if_busy_cycles", 32'(busy), 32'(exp_busy));
      check("if_latency", 32'(n), 32'(exp_busy + 2));
      check("if_stall_cycles", 32'(stl), 32'(n - 1));
    end
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic dm_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input int exp_we);
    int n, wec;
    bit seen;
    dm_exp_q.push_back(we ? 32'h0 : ref_arr[a[9:2]]);
    if (we) ref_arr[a[9:2]] = wd;
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    n = 0; wec = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_we) wec++;
      if (dm_valid) seen = 1'b1;
    end
    check("dm_done", 32'(seen), 32'(1));
    if (exp_we >= 0) check("dm_we_cycles", 32'(wec), 32'(exp_we));
    @(posedge clk);
    #1;
    dm_req = 1'b0;
    dm_we  = 1'b0;
  endtask

  task automatic wait_state(input arb_state_t s, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_state != s && n < 50);
    check(tag, 32'(dbg_state), 32'(s));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [DATA_W-1:0] saved;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = init_word(i);
      ref_arr[i] = init_word(i);
    end
    reset = 1'b0; lat = 2; spur = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'(0));
    check("rst_dm_valid", 32'(dm_valid), 32'(0));
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_stall", 32'(stall), 32'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // First tie after reset goes to DM, then IF is served.
    grant_q.delete();
    fork
      if_fetch(32'h0000_0008, 0, 1'b0);
      dm_access(1'b0, 32'h0000_000C, 32'h0, -1);
    join
    check("tie1_grants", 32'(grant_q.size()), 32'(2));
    check("tie1_first_dm", 32'(grant_q[0]), 32'(1));
    check("tie1_second_if", 32'(grant_q[1]), 32'(0));

    // IF only, two wait states.
    if_fetch(32'h0000_0000, 3, 1'b1);

    // Store 7 to 0x4 then load it back.
    dm_access(1'b1, 32'h0000_0004, 32'h0000_0007, 3);
    dm_access(1'b0, 32'h0000_0004, 32'h0, 0);

    // Last grant was DM, so the next tie goes to IF.
    grant_q.delete();
    fork
      if_fetch(32'h0000_0004, 0, 1'b0);
      dm_access(1'b0, 32'h0000_0020, 32'h0, -1);
    join
    check("tie2_grants", 32'(grant_q.size()), 32'(2));
    check("tie2_first_if", 32'(grant_q[0]), 32'(0));
    check("tie2_second_dm", 32'(grant_q[1]), 32'(1));

    // Flush one cycle into an IF transaction: result dropped.
    lat = 3;
    saved = if_rdata;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    wait_state(BUSY_IF, "flush1_granted");
    if_flush = 1'b1; if_req = 1'b0;
    @(posedge clk);
    #1;
    if_flush = 1'b0;
    wait_state(IDLE, "flush1_idle");
    repeat (2) @(negedge clk);
    check("flush1_rdata_kept", if_rdata, saved);
    @(posedge clk);
    #1;
    if_fetch(32'h0000_0050, 4, 1'b1);

    // Flush arriving in the ack cycle also drops the fetch.
    lat = 1;
    saved = if_rdata;
    if_req = 1'b1; if_addr = 32'h0000_0014;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(mem_ack && dbg_state == BUSY_IF) && n < 50);
      check("flush2_ack_seen", 32'(mem_ack), 32'(1));
    end
    if_flush = 1'b1;
    @(posedge clk);
    #1;
    if_flush = 1'b0; if_req = 1'b0;
    repeat (3) @(negedge clk);
    check("flush2_rdata_kept", if_rdata, saved);
    @(posedge clk);
    #1;

    // Zero-wait memory.
    lat = 0;
    if_fetch(32'h0000_0018, 1, 1'b1);
    dm_access(1'b0, 32'h0000_001C, 32'h0, 0);

    // Spurious ack while idle.
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    check("spur_state", 32'(dbg_state), 32'(IDLE));
    check("spur_mem_req", 32'(mem_req), 32'(0));

    // Reset in the middle of a DM load, then the held request completes.
    @(posedge clk);
    #1;
    lat = 5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0024;
    wait_state(BUSY_DM, "rst_mid_busy");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'(0));
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_dm_valid", 32'(dm_valid), 32'(0));
    end
    lat = 2;
    dm_exp_q.push_back(ref_arr[9]);
    reset = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!dm_valid && n < 50);
      check("rst_reissue_done", 32'(dm_valid), 32'(1));
    end
    @(posedge clk);
    #1;
    dm_req = 1'b0;

    repeat (4) @(negedge clk);
    check("if_queue_empty", 32'(if_exp_q.size()), 32'(0));
    check("dm_queue_empty", 32'(dm_exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
